// File: rtl/rom_rd_arb_pkg.sv
// rom_rd_arb_pkg
//   Shared helpers for the ROM read arbiter and any ROM instance wrapper that
//   must agree with it on read latency and width derivations.
//   rd_lat(rdtype) : ROM read latency in cycles (0 async, 1/2 one register, 3 two)
//   id_w(nreq)     : requester id width, never less than 1
//   addr_w(depth)  : address width for a given total entry count, never less than 1
package rom_rd_arb_pkg;

  function automatic int rd_lat(input logic [1:0] rdtype);
    case (rdtype)
      2'd0:    return 0;
      2'd3:    return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int id_w(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rom_rd_arb_rr_arb.sv
// rr_arb
//   Purely combinational round-robin picker. Searches req starting at ptr,
//   wrapping modulo NREQ, and grants the first set bit when en is high.
//   req     : request vector
//   ptr     : search start index (values >= NREQ wrap)
//   en      : grant enable
//   gnt     : one-hot grant (all zero when nothing granted)
//   gnt_idx : encoded index of the granted requester (0 when nothing granted)
module rr_arb
  import rom_rd_arb_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic           found;
  logic [IDW-1:0] pos;

  always_comb begin
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    pos     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IDW'((int'(ptr) + k) % NREQ);
      if (en && !found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/rom_rd_arb.sv
// rom_rd_arb
//   Round-robin read arbiter and latency sequencer sharing one single-port ROM
//   among NREQ requesters. Grants are combinational and drive the ROM directly;
//   a {valid,id} shift register matching the ROM latency tags each read so the
//   returned data is registered and strobed to the owning requester.
//   clk, rst_n : clock, async active-low reset
//   req_valid  : per-requester request valid
//   req_addr   : packed per-requester addresses, requester i at [i*ADDR_BITS +: ADDR_BITS]
//   req_ready  : one-hot grant (transfer on valid & ready)
//   halt       : blocks new grants; in-flight reads still complete
//   mem_me     : ROM enable, mem_addr : ROM address, mem_rdata : ROM data
//   rsp_valid  : one-hot single-cycle response strobe
//   rsp_data   : registered read data, held when rsp_valid is 0
//   idle       : nothing in flight and no response being presented
module rom_rd_arb
  import rom_rd_arb_pkg::*;
#(
  parameter int         NREQ      = 4,
  parameter int         BLKS      = 2,
  parameter int         BDEPTH    = 32,
  parameter int         SEGS      = 1,
  parameter int         SEGW      = 32,
  parameter logic [1:0] RDTYPE    = 2'd1,
  localparam int        ADDR_BITS = addr_w(BLKS * BDEPTH),
  localparam int        DW        = SEGS * SEGW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*ADDR_BITS-1:0] req_addr,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      halt,
  output logic                      mem_me,
  output logic [ADDR_BITS-1:0]      mem_addr,
  input  logic [DW-1:0]             mem_rdata,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DW-1:0]             rsp_data,
  output logic                      idle
);

  localparam int RD_LAT = rd_lat(RDTYPE);
  localparam int IDW    = id_w(NREQ);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            arb_en;

  logic            tail_v;
  logic [IDW-1:0]  tail_id;
  logic            pipe_busy;

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  // Gating with rst_n keeps req_ready/mem_me low while reset is held.
  assign arb_en = ~halt & rst_n;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any   = |gnt;
  assign req_ready = gnt;
  assign mem_me    = gnt_any;

  always_comb begin
    mem_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) mem_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (NREQ == 1 || gnt_idx == IDW'(NREQ - 1)) ptr_d = '0;
      else                                        ptr_d = gnt_idx + IDW'(1);
    end
  end

  // Tracks each read through the ROM latency; the tail stage lines up with
  // the cycle in which mem_rdata is valid for that read.
  if (RD_LAT == 0) begin : g_nopipe
    assign tail_v    = gnt_any;
    assign tail_id   = gnt_idx;
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    logic [RD_LAT-1:0] pv_q, pv_d;
    logic [IDW-1:0]    pid_q [RD_LAT];
    logic [IDW-1:0]    pid_d [RD_LAT];

    always_comb begin
      pv_d     = '0;
      pv_d[0]  = gnt_any;
      pid_d[0] = gnt_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_d[i]  = pv_q[i-1];
        pid_d[i] = pid_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q <= '0;
        for (int i = 0; i < RD_LAT; i++) pid_q[i] <= '0;
      end else begin
        pv_q  <= pv_d;
        pid_q <= pid_d;
      end
    end

    assign tail_v    = pv_q[RD_LAT-1];
    assign tail_id   = pid_q[RD_LAT-1];
    assign pipe_busy = |pv_q;
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tail_v) begin
      rsp_data_d = mem_rdata;
      for (int i = 0; i < NREQ; i++) begin
        rsp_valid_d[i] = (tail_id == IDW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = ~pipe_busy & ~(|rsp_valid_q);

endmodule

// File: tb/tb_rom_rd_arb.sv
// tb_rom_rd_arb
//   Directed bench: three arbiters (RDTYPE 1, 3, 0) share the same requester
//   stimulus, each attached to its own behavioural ROM whose entry k = 0x100+k.
module tb_rom_rd_arb;

  localparam int NREQ = 4;
  localparam int AB   = 6;
  localparam int DW   = 32;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*AB-1:0] req_addr;
  logic            halt;

  logic [NREQ-1:0] ready1, ready3, ready0;
  logic            me1, me3, me0;
  logic [AB-1:0]   addr1, addr3, addr0;
  logic [DW-1:0]   rdata1, rdata3, rdata0;
  logic [NREQ-1:0] rspv1, rspv3, rspv0;
  logic [DW-1:0]   rspd1, rspd3, rspd0;
  logic            idle1, idle3, idle0;

  int errors = 0;
  int checks = 0;

  rom_rd_arb #(.NREQ(NREQ), .BLKS(2), .BDEPTH(32), .SEGS(1), .SEGW(32), .RDTYPE(2'd1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(ready1),
    .halt(halt), .mem_me(me1), .mem_addr(addr1), .mem_rdata(rdata1),
    .rsp_valid(rspv1), .rsp_data(rspd1), .idle(idle1));

  rom_rd_arb #(.NREQ(NREQ), .BLKS(2), .BDEPTH(32), .SEGS(1), .SEGW(32), .RDTYPE(2'd3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(ready3),
    .halt(halt), .mem_me(me3), .mem_addr(addr3), .mem_rdata(rdata3),
    .rsp_valid(rspv3), .rsp_data(rspd3), .idle(idle3));

  rom_rd_arb #(.NREQ(NREQ), .BLKS(2), .BDEPTH(32), .SEGS(1), .SEGW(32), .RDTYPE(2'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(ready0),
    .halt(halt), .mem_me(me0), .mem_addr(addr0), .mem_rdata(rdata0),
    .rsp_valid(rspv0), .rsp_data(rspd0), .idle(idle0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_val(input logic [AB-1:0] a);
    return 32'h100 + {26'd0, a};
  endfunction

  // ROM models: RDTYPE 1 registers the address, RDTYPE 3 registers address
  // and data, RDTYPE 0 is a purely combinational lookup.
  logic [AB-1:0] a1_q = '0;
  logic [AB-1:0] a3_q = '0;
  logic [DW-1:0] d3_q = '0;
  always @(posedge clk) begin
    if (me1) a1_q <= addr1;
    if (me3) a3_q <= addr3;
    d3_q <= rom_val(a3_q);
  end
  assign rdata1 = rom_val(a1_q);
  assign rdata3 = d3_q;
  assign rdata0 = rom_val(addr0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AB-1:0] a);
    req_addr[i*AB +: AB] = a;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int exp_g [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n     = 1'b0;
    halt      = 1'b0;
    req_valid = 4'b1111;
    req_addr  = '0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(ready1), 32'h0);
    chk("rst_me", 32'(me1), 32'h0);
    chk("rst_addr", 32'(addr1), 32'h0);
    chk("rst_rspv", 32'(rspv1), 32'h0);
    chk("rst_rspd", rspd1, 32'h0);
    chk("rst_idle", 32'(idle1), 32'h1);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    tick();

    // Single read, requester 2 addr 5 at T
    req_valid = 4'b0100; set_addr(2, 6'd5); #1;
    chk("t1_ready", 32'(ready1), 32'h4);
    chk("t1_me", 32'(me1), 32'h1);
    chk("t1_addr", 32'(addr1), 32'd5);
    tick(); req_valid = 4'b0000; #1;                     // T+1
    chk("t1_rspv_t1", 32'(rspv1), 32'h0);
    chk("t1_idle_t1", 32'(idle1), 32'h0);
    chk("t1_rd0_v", 32'(rspv0), 32'h4);
    chk("t1_rd0_d", rspd0, 32'h105);
    tick();                                              // T+2
    chk("t1_rspv", 32'(rspv1), 32'h4);
    chk("t1_rspd", rspd1, 32'h105);
    chk("t1_rd3_early", 32'(rspv3), 32'h0);
    tick();                                              // T+3
    chk("t1_rspv_off", 32'(rspv1), 32'h0);
    chk("t1_rspd_hold", rspd1, 32'h105);
    chk("t1_idle_end", 32'(idle1), 32'h1);
    chk("t1_rd3_v", 32'(rspv3), 32'h4);
    chk("t1_rd3_d", rspd3, 32'h105);
    tick(); tick();

    // Reset pulse so the pointer starts from 0, then continuous requests
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_addr(i, 6'(10 + i));
    tick();
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 5) begin
        chk("t2_ready", 32'(ready1), 32'(1 << exp_g[k]));
        chk("t2_addr", 32'(addr1), 32'(10 + exp_g[k]));
      end else begin
        chk("t2_ready_off", 32'(ready1), 32'h0);
      end
      if (k >= 2) begin
        chk("t2_rspv", 32'(rspv1), 32'(1 << exp_g[k-2]));
        chk("t2_rspd", rspd1, 32'h100 + 32'(10 + exp_g[k-2]));
      end else begin
        chk("t2_rspv_none", 32'(rspv1), 32'h0);
      end
      tick();
    end
    tick(); tick(); tick();

    // RDTYPE 3: requester 1 addr 40 (pointer is 1 here)
    req_valid = 4'b0010; set_addr(1, 6'd40); #1;
    chk("t3_ready", 32'(ready3), 32'h2);
    chk("t3_idle_t0", 32'(idle3), 32'h1);
    tick(); req_valid = 4'b0000; #1;                     // T+1
    chk("t3_idle_t1", 32'(idle3), 32'h0);
    chk("t3_rspv_t1", 32'(rspv3), 32'h0);
    tick();                                              // T+2
    chk("t3_idle_t2", 32'(idle3), 32'h0);
    chk("t3_rspv_t2", 32'(rspv3), 32'h0);
    tick();                                              // T+3
    chk("t3_rspv", 32'(rspv3), 32'h2);
    chk("t3_rspd", rspd3, 32'h128);
    chk("t3_idle_t3", 32'(idle3), 32'h0);
    tick();                                              // T+4
    chk("t3_idle_t4", 32'(idle3), 32'h1);
    chk("t3_rspv_t4", 32'(rspv3), 32'h0);
    tick();

    // RDTYPE 0: addr 0 from requester 2 (pointer is 2 here)
    req_valid = 4'b0100; set_addr(2, 6'd0); #1;
    chk("t4_me", 32'(me0), 32'h1);
    chk("t4_addr", 32'(addr0), 32'h0);
    tick(); req_valid = 4'b0000; #1;                     // T+1
    chk("t4_rspv", 32'(rspv0), 32'h4);
    chk("t4_rspd", rspd0, 32'h100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_me_quiet", 32'(me0), 32'h0);
      chk("t4_idle_quiet", 32'(idle0), 32'h1);
    end

    // Halt with three reads in flight on RDTYPE 3 (pointer is 3 here)
    for (int i = 0; i < NREQ; i++) set_addr(i, 6'(20 + i));
    req_valid = 4'b1111; #1;
    chk("t5_g0", 32'(ready3), 32'h8);                    // H0
    tick(); chk("t5_g1", 32'(ready3), 32'h1);            // H1
    tick(); chk("t5_g2", 32'(ready3), 32'h2);            // H2
    tick(); halt = 1'b1; #1;                             // H3
    chk("t5_halt_ready", 32'(ready3), 32'h0);
    chk("t5_halt_me", 32'(me3), 32'h0);
    chk("t5_rspv_a", 32'(rspv3), 32'h8);
    chk("t5_rspd_a", rspd3, 32'h117);
    tick();                                              // H4
    chk("t5_halt_ready2", 32'(ready3), 32'h0);
    chk("t5_rspv_b", 32'(rspv3), 32'h1);
    chk("t5_rspd_b", rspd3, 32'h114);
    tick();                                              // H5
    chk("t5_rspv_c", 32'(rspv3), 32'h2);
    chk("t5_rspd_c", rspd3, 32'h115);
    tick();                                              // H6
    chk("t5_halt_ready3", 32'(ready3), 32'h0);
    chk("t5_idle", 32'(idle3), 32'h1);
    tick(); halt = 1'b0; #1;                             // H7
    chk("t5_resume", 32'(ready3), 32'h4);
    chk("t5_resume_addr", 32'(addr3), 32'd22);
    tick(); req_valid = 4'b0000;
    tick(); tick(); tick(); tick();

    // Reset mid-operation (pointer is 3 here)
    req_valid = 4'b1111; #1;
    chk("t6_g0", 32'(ready1), 32'h8);                    // G0
    tick(); chk("t6_g1", 32'(ready1), 32'h1);            // G1
    tick(); rst_n = 1'b0; req_valid = 4'b0000; #1;       // G2
    for (int k = 0; k < 5; k++) begin
      if (k == 1) rst_n = 1'b1;
      #1;
      chk("t6_rspv1", 32'(rspv1), 32'h0);
      chk("t6_rspv3", 32'(rspv3), 32'h0);
      chk("t6_rspv0", 32'(rspv0), 32'h0);
      tick();
    end
    req_valid = 4'b1001; #1;                             // G7: pointer back at 0
    chk("t6_ptr0", 32'(ready1), 32'h1);
    tick(); req_valid = 4'b1000; #1;                     // G8
    chk("t6_req3", 32'(ready1), 32'h8);
    tick(); req_valid = 4'b0000; #1;                     // G9
    chk("t6_rspv_new", 32'(rspv1), 32'h1);
    chk("t6_rspd_new", rspd1, 32'h114);
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
